// File: rtl/ddr_index_addr_gen_if.sv
// ---------------------------------------------------------------------------
// ddr_index_addr_gen_if
//
// Purpose:
//   Groups the two streaming handshakes of the index-to-DDR-address generator.
//   The request side carries a burst (start index, beat count) from the line
//   scheduler. The address side carries one DDR address per beat to the DDR
//   command generator.
//
// Signals:
//   req_valid   requester -> generator   burst request valid
//   req_ready   generator -> requester   generator idle and clock-enabled
//   req_idx     requester -> generator   start line index   [IDX_W]
//   req_len     requester -> generator   beats in the burst [LEN_W]
//   addr_valid  generator -> consumer    address beat valid
//   addr_ready  consumer  -> generator   consumer takes the beat
//   addr        generator -> consumer    DDR address        [ADDR_W]
//   addr_sat    generator -> consumer    beat index was out of range
//   addr_last   generator -> consumer    final beat of the burst
//
// Modports:
//   master  the side that issues requests and consumes addresses
//           (scheduler / testbench)
//   slave   the address generator itself
// ---------------------------------------------------------------------------
interface ddr_index_addr_gen_if #(
    parameter int IDX_W  = 10,
    parameter int LEN_W  = 8,
    parameter int ADDR_W = 12
);

    logic              req_valid;
    logic              req_ready;
    logic [IDX_W-1:0]  req_idx;
    logic [LEN_W-1:0]  req_len;

    logic              addr_valid;
    logic              addr_ready;
    logic [ADDR_W-1:0] addr;
    logic              addr_sat;
    logic              addr_last;

    modport master (
        output req_valid,
        output req_idx,
        output req_len,
        input  req_ready,
        input  addr_valid,
        input  addr,
        input  addr_sat,
        input  addr_last,
        output addr_ready
    );

    modport slave (
        input  req_valid,
        input  req_idx,
        input  req_len,
        output req_ready,
        output addr_valid,
        output addr,
        output addr_sat,
        output addr_last,
        input  addr_ready
    );

endinterface

// File: rtl/ddr_index_addr_gen.sv
// ---------------------------------------------------------------------------
// ddr_index_addr_gen
//
// Purpose:
//   Turns a burst request (start line index, beat count) into a stream of DDR
//   addresses. The address is computed as addr = BASE + idx*STRIDE. One
//   multiply is done per burst, for the first beat. Every later beat adds
//   STRIDE to the previous address.
//
//   The generator sits between the line scheduler and the DDR read/write
//   command generator. It replaces the old fixed index->address ROM.
//
// Ports:
//   clk     in   single clock; all logic is on the rising edge
//   reset   in   synchronous, active-high; a reset mid-burst drops the burst
//   ce      in   clock enable; 0 freezes every register and forces
//                req_ready low
//   bus     slave modport of ddr_index_addr_gen_if; carries the request
//           handshake (req_*) and the address handshake (addr_*)
//   busy    out  high whenever the FSM is not in IDLE
//
// Index range handling:
//   DDR_INDEX_WRAP_EN undefined (default):
//     Saturate mode. Any beat whose index is >= NUM_IDX reports ADDR_MAX
//     with addr_sat=1, and the index stops advancing.
//   DDR_INDEX_WRAP_EN defined:
//     Wrap mode. The index wraps modulo NUM_IDX. The wrapped beat, and a
//     first beat whose start index is out of range, report BASE with
//     addr_sat=1. ADDR_MAX is never emitted in this mode.
//
// Timing:
//   A request accepted on edge T gives its first addr_valid after edge T+2
//   (CALC registers the product; the first RUN cycle loads the output
//   register). After that the generator sustains one beat per clock.
//   The only combinational path to an output is ce/state -> req_ready.
// ---------------------------------------------------------------------------
module ddr_index_addr_gen #(
    parameter int IDX_W   = 10,
    parameter int LEN_W   = 8,
    parameter int ADDR_W  = 12,
    parameter int STRIDE  = 6,
    parameter int BASE    = 0,
    parameter int NUM_IDX = 680
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    ddr_index_addr_gen_if.slave   bus,
    output logic                  busy
);

    localparam logic [ADDR_W-1:0] BASE_C    = ADDR_W'(BASE);
    localparam logic [ADDR_W-1:0] STRIDE_C  = ADDR_W'(STRIDE);
    localparam logic [IDX_W:0]    NUM_IDX_C = (IDX_W+1)'(NUM_IDX);
    localparam logic [IDX_W:0]    IDX_ONE   = (IDX_W+1)'(1);
    localparam logic [LEN_W-1:0]  LEN_ONE   = LEN_W'(1);
    localparam logic [LEN_W-1:0]  LEN_TWO   = LEN_W'(2);
`ifndef DDR_INDEX_WRAP_EN
    localparam logic [ADDR_W-1:0] ADDR_MAX  = ADDR_W'(BASE + NUM_IDX * STRIDE);
`endif

    // The clamp value BASE + NUM_IDX*STRIDE must fit in the address bus.
    // Otherwise the saturated address would silently alias a real line.
    generate
        if (BASE + NUM_IDX * STRIDE >= (1 << ADDR_W)) begin : g_addr_range_check
            $error("ddr_index_addr_gen: BASE + NUM_IDX*STRIDE does not fit in ADDR_W bits");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        RUN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W:0]     r_idx;
    logic [LEN_W-1:0]   r_remaining;
    logic [ADDR_W-1:0]  r_prod;
    logic               r_prod_sat;
    logic               r_addr_valid;
    logic [ADDR_W-1:0]  r_addr;
    logic               r_addr_sat;
    logic               r_addr_last;

    logic [ADDR_W-1:0]  w_mul_addr;
    logic [IDX_W:0]     w_calc_idx;
    logic [ADDR_W-1:0]  w_calc_addr;
    logic               w_calc_sat;
    logic [IDX_W:0]     w_idx_inc;
    logic [IDX_W:0]     w_step_idx;
    logic [ADDR_W-1:0]  w_step_addr;
    logic               w_step_sat;

    // Outputs come straight from registers. req_ready is the exception:
    // it must drop at once when ce is low, so it is decoded from ce and state.
    assign bus.req_ready  = ce && (r_state == IDLE);
    assign bus.addr_valid = r_addr_valid;
    assign bus.addr       = r_addr;
    assign bus.addr_sat   = r_addr_sat;
    assign bus.addr_last  = r_addr_last;
    assign busy           = (r_state != IDLE);

    // First-beat address of the burst: the only place the multiplier is used.
    // An out-of-range start index bypasses the product. In saturate mode it
    // becomes ADDR_MAX; in wrap mode it restarts at index 0 (address BASE).
    // Either way the beat is flagged with addr_sat.
    always_comb begin
        w_mul_addr  = BASE_C + ADDR_W'(r_idx) * STRIDE_C;
        w_calc_idx  = r_idx;
        w_calc_addr = w_mul_addr;
        w_calc_sat  = 1'b0;
        if (r_idx >= NUM_IDX_C) begin
`ifdef DDR_INDEX_WRAP_EN
            w_calc_idx  = '0;
            w_calc_addr = BASE_C;
`else
            w_calc_addr = ADDR_MAX;
`endif
            w_calc_sat  = 1'b1;
        end
    end

    // Follow-on beats advance the address with an adder rather than the
    // multiplier. The index register is one bit wider than req_idx, so
    // "index + 1" never wraps before it is compared against NUM_IDX.
    // In saturate mode the index freezes once it is out of range. In wrap
    // mode only the beat that rolls back to 0 carries addr_sat.
    always_comb begin
        w_idx_inc   = r_idx + IDX_ONE;
        w_step_idx  = w_idx_inc;
        w_step_addr = r_addr + STRIDE_C;
        w_step_sat  = 1'b0;
`ifdef DDR_INDEX_WRAP_EN
        if (w_idx_inc == NUM_IDX_C) begin
            w_step_idx  = '0;
            w_step_addr = BASE_C;
            w_step_sat  = 1'b1;
        end
`else
        if (r_idx >= NUM_IDX_C) begin
            w_step_idx  = r_idx;
            w_step_addr = ADDR_MAX;
            w_step_sat  = 1'b1;
        end else if (w_idx_inc >= NUM_IDX_C) begin
            w_step_addr = ADDR_MAX;
            w_step_sat  = 1'b1;
        end
`endif
    end

    // Main FSM: IDLE -> CALC -> RUN -> IDLE.
    //   IDLE  Latch the request. A zero-length burst is acknowledged and
    //         dropped without leaving IDLE.
    //   CALC  Register the first-beat product.
    //   RUN   The first cycle loads the output register from the product.
    //         After that, every accepted beat either loads the next address
    //         or, after the last beat, returns to IDLE.
    // r_remaining counts the beats still to transfer, including the one on
    // the bus. addr_last is therefore "remaining == 1" for the beat being
    // presented. ce low holds every register, so stalled beats stay frozen.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= IDLE;
            r_idx        <= '0;
            r_remaining  <= '0;
            r_prod       <= '0;
            r_prod_sat   <= 1'b0;
            r_addr_valid <= 1'b0;
            r_addr       <= '0;
            r_addr_sat   <= 1'b0;
            r_addr_last  <= 1'b0;
        end else if (ce) begin
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_idx       <= {1'b0, bus.req_idx};
                        r_remaining <= bus.req_len;
                        if (bus.req_len != '0) begin
                            r_state <= CALC;
                        end
                    end
                end

                CALC: begin
                    r_idx      <= w_calc_idx;
                    r_prod     <= w_calc_addr;
                    r_prod_sat <= w_calc_sat;
                    r_state    <= RUN;
                end

                RUN: begin
                    if (!r_addr_valid) begin
                        r_addr_valid <= 1'b1;
                        r_addr       <= r_prod;
                        r_addr_sat   <= r_prod_sat;
                        r_addr_last  <= (r_remaining == LEN_ONE);
                    end else if (bus.addr_ready) begin
                        if (r_remaining == LEN_ONE) begin
                            r_addr_valid <= 1'b0;
                            r_addr_last  <= 1'b0;
                            r_state      <= IDLE;
                        end else begin
                            r_remaining <= r_remaining - LEN_ONE;
                            r_idx       <= w_step_idx;
                            r_addr      <= w_step_addr;
                            r_addr_sat  <= w_step_sat;
                            r_addr_last <= (r_remaining == LEN_TWO);
                        end
                    end
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ddr_index_addr_gen.sv
// ---------------------------------------------------------------------------
// tb_ddr_index_addr_gen
//
// Purpose:
//   Self-checking bench for ddr_index_addr_gen.
//   - A table of hand-computed bursts is applied first.
//   - Hand-written sequences follow, covering zero-length bursts, clock
//     enable freeze and reset mid-burst.
//   - Randomized bursts are then checked against a reference model.
//     The model computes each beat directly from its position in the burst,
//     using BASE + index*STRIDE with clamp or modulo.
//
// Build option: DDR_INDEX_WRAP_EN selects the wrap-mode expectations,
// matching the RTL.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ddr_index_addr_gen;

    localparam int IDX_W    = 10;
    localparam int LEN_W    = 8;
    localparam int ADDR_W   = 12;
    localparam int STRIDE   = 6;
    localparam int BASE     = 0;
    localparam int NUM_IDX  = 680;
    localparam int ADDR_MAX = BASE + NUM_IDX * STRIDE;

    typedef struct packed {
        logic [9:0]       idx;
        logic [7:0]       len;
        logic [1:0]       mode;
        logic [3:0][11:0] a;
        logic [3:0]       sat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic ce;
    logic busy;
    int   checks = 0;
    int   errors = 0;

    int gotAddr[$];
    bit gotSat[$];
    bit gotLast[$];
    bit readyPattern[5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    ddr_index_addr_gen_if #(.IDX_W(IDX_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W)) bus ();

    ddr_index_addr_gen #(
        .IDX_W(IDX_W), .LEN_W(LEN_W), .ADDR_W(ADDR_W),
        .STRIDE(STRIDE), .BASE(BASE), .NUM_IDX(NUM_IDX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .ce(ce),
        .bus(bus),
        .busy(busy)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    // Watchdog so a stuck handshake cannot hang the run.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one value and keep the running totals.
    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
        end
    endtask

    task automatic timeoutFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s actual=timeout required=handshake", name);
    endtask

    // Reference beat k of a burst (idx, len), computed from the addressing rules.
    function automatic void modelBeat(input int idx, input int len, input int k,
                                      output int a, output bit s, output bit l);
`ifdef DDR_INDEX_WRAP_EN
        int start;
        int i;
        start = (idx >= NUM_IDX) ? 0 : idx;
        i     = (start + k) % NUM_IDX;
        a     = BASE + i * STRIDE;
        s     = (k == 0) ? (idx >= NUM_IDX) : (i == 0);
`else
        int i;
        i = idx + k;
        if (i >= NUM_IDX) begin
            a = ADDR_MAX;
            s = 1'b1;
        end else begin
            a = BASE + i * STRIDE;
            s = 1'b0;
        end
`endif
        l = (k == len - 1);
    endfunction

    function automatic vec_t mkVec(input int idx, input int len, input int mode,
                                   input int a0, input int a1, input int a2, input int a3,
                                   input logic [3:0] sat);
        vec_t v;
        v.idx  = 10'(idx);
        v.len  = 8'(len);
        v.mode = 2'(mode);
        v.a[0] = 12'(a0);
        v.a[1] = 12'(a1);
        v.a[2] = 12'(a2);
        v.a[3] = 12'(a3);
        v.sat  = sat;
        return v;
    endfunction

    // Present a request at a negedge and hold it until it is accepted.
    // Returns at the negedge following the accepting edge.
    task automatic applyStimulus(input logic [9:0] idx, input logic [7:0] len);
        int w;
        w = 0;
        bus.req_valid = 1'b1;
        bus.req_idx   = idx;
        bus.req_len   = len;
        while (bus.req_ready !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (bus.req_ready !== 1'b1) timeoutFail("req_accept");
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic waitValid(input string name);
        int w;
        w = 0;
        while (bus.addr_valid !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (bus.addr_valid !== 1'b1) timeoutFail(name);
    endtask

    // Collect len beats. Ready modes: 0 = always ready, 1 = random,
    // 2 = readyPattern applied to valid cycles.
    // firstWait is the number of negedges before addr_valid was first seen.
    // While stalled, the presented beat must not change.
    task automatic collectBurst(input int len, input int mode, output int firstWait);
        int cyc;
        int got;
        int pidx;
        bit stalled;
        bit r;
        logic [11:0] hA;
        logic hS;
        logic hL;
        gotAddr.delete();
        gotSat.delete();
        gotLast.delete();
        cyc = 0;
        got = 0;
        pidx = 0;
        stalled = 1'b0;
        firstWait = -1;
        hA = '0;
        hS = 1'b0;
        hL = 1'b0;
        while (got < len && cyc < len * 4 + 40) begin
            if (stalled) begin
                checkOutput("stall_valid", bus.addr_valid, 1);
                checkOutput("stall_addr", bus.addr, hA);
                checkOutput("stall_sat", bus.addr_sat, hS);
                checkOutput("stall_last", bus.addr_last, hL);
            end
            if (bus.addr_valid === 1'b1 && firstWait < 0) firstWait = cyc;
            case (mode)
                1:       r = 1'($urandom_range(0, 1));
                2:       r = (bus.addr_valid === 1'b1 && pidx < 5) ? readyPattern[pidx] : 1'b1;
                default: r = 1'b1;
            endcase
            if (mode == 2 && bus.addr_valid === 1'b1) pidx++;
            bus.addr_ready = r;
            if (bus.addr_valid === 1'b1 && r) begin
                gotAddr.push_back(int'(bus.addr));
                gotSat.push_back(bus.addr_sat);
                gotLast.push_back(bus.addr_last);
                got++;
                stalled = 1'b0;
            end else if (bus.addr_valid === 1'b1) begin
                stalled = 1'b1;
                hA = bus.addr;
                hS = bus.addr_sat;
                hL = bus.addr_last;
            end else begin
                stalled = 1'b0;
            end
            @(negedge clk);
            cyc++;
        end
        bus.addr_ready = 1'b1;
        if (got < len) timeoutFail("burst_beats");
    endtask

    // Compare the collected beats against the model, starting at beat 'skip'.
    task automatic checkModel(input string tag, input int idx, input int len, input int skip);
        int a;
        bit s;
        bit l;
        checkOutput({tag, "_count"}, gotAddr.size(), len - skip);
        for (int k = 0; k < gotAddr.size() && k < len - skip; k++) begin
            modelBeat(idx, len, k + skip, a, s, l);
            checkOutput($sformatf("%s_addr%0d", tag, k), gotAddr[k], a);
            checkOutput($sformatf("%s_sat%0d", tag, k), gotSat[k], s);
            checkOutput($sformatf("%s_last%0d", tag, k), gotLast[k], l);
        end
        checkOutput({tag, "_valid_end"}, bus.addr_valid, 0);
        checkOutput({tag, "_ready_end"}, bus.req_ready, 1);
    endtask

    initial begin
        vec_t vecs[5];
        int fw;
        int a;
        bit s;
        bit l;
        int ridx;
        int rlen;

        vecs[0] = mkVec(0, 4, 0, 'h000, 'h006, 'h00C, 'h012, 4'b0000);
        vecs[2] = mkVec(10, 3, 2, 'h03C, 'h042, 'h048, 'h000, 4'b0000);
`ifdef DDR_INDEX_WRAP_EN
        vecs[1] = mkVec(678, 4, 1, 'hFE4, 'hFEA, 'h000, 'h006, 4'b0100);
        vecs[3] = mkVec(700, 1, 0, 'h000, 'h000, 'h000, 'h000, 4'b0001);
        vecs[4] = mkVec(679, 2, 0, 'hFEA, 'h000, 'h000, 'h000, 4'b0010);
`else
        vecs[1] = mkVec(678, 4, 1, 'hFE4, 'hFEA, 'hFF0, 'hFF0, 4'b1100);
        vecs[3] = mkVec(1023, 2, 0, 'hFF0, 'hFF0, 'h000, 'h000, 4'b0011);
        vecs[4] = mkVec(679, 1, 0, 'hFEA, 'h000, 'h000, 'h000, 4'b0000);
`endif

        reset          = 1'b1;
        ce             = 1'b1;
        bus.req_valid  = 1'b0;
        bus.req_idx    = '0;
        bus.req_len    = '0;
        bus.addr_ready = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("rst_valid", bus.addr_valid, 0);
        checkOutput("rst_addr", bus.addr, 0);
        checkOutput("rst_sat", bus.addr_sat, 0);
        checkOutput("rst_last", bus.addr_last, 0);
        checkOutput("rst_busy", busy, 0);
        reset = 1'b0;
        @(negedge clk);
        checkOutput("idle_ready", bus.req_ready, 1);

        // Directed table of bursts with hand-computed addresses.
        for (int v = 0; v < 5; v++) begin
            applyStimulus(vecs[v].idx, vecs[v].len);
            collectBurst(int'(vecs[v].len), int'(vecs[v].mode), fw);
            checkOutput($sformatf("v%0d_latency", v), fw, 2);
            checkOutput($sformatf("v%0d_count", v), gotAddr.size(), int'(vecs[v].len));
            for (int k = 0; k < int'(vecs[v].len) && k < gotAddr.size(); k++) begin
                checkOutput($sformatf("v%0d_addr%0d", v, k), gotAddr[k], vecs[v].a[k]);
                checkOutput($sformatf("v%0d_sat%0d", v, k), gotSat[k], vecs[v].sat[k]);
                checkOutput($sformatf("v%0d_last%0d", v, k), gotLast[k], (k == int'(vecs[v].len) - 1));
            end
            checkOutput($sformatf("v%0d_valid_end", v), bus.addr_valid, 0);
            checkOutput($sformatf("v%0d_ready_end", v), bus.req_ready, 1);
        end

        // Zero-length request: acknowledged, nothing emitted.
        applyStimulus(10'd5, 8'd0);
        checkOutput("len0_ready", bus.req_ready, 1);
        for (int c = 0; c < 4; c++) begin
            checkOutput("len0_valid", bus.addr_valid, 0);
            checkOutput("len0_busy", busy, 0);
            @(negedge clk);
        end

        // ce low in IDLE: no ready and a pending request is not taken.
        ce = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_idx   = 10'd1;
        bus.req_len   = 8'd2;
        @(negedge clk);
        checkOutput("ce_idle_ready", bus.req_ready, 0);
        @(negedge clk);
        checkOutput("ce_idle_busy", busy, 0);
        bus.req_valid = 1'b0;
        ce = 1'b1;
        @(negedge clk);

        // ce low for 5 cycles mid-burst: everything holds, then the burst resumes.
        applyStimulus(10'd20, 8'd6);
        waitValid("ce_wait_valid");
        @(negedge clk);
        ce = 1'b0;
        modelBeat(20, 6, 1, a, s, l);
        checkOutput("ce_snap_addr", bus.addr, a);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            checkOutput("ce_frz_valid", bus.addr_valid, 1);
            checkOutput("ce_frz_addr", bus.addr, a);
            checkOutput("ce_frz_last", bus.addr_last, 0);
            checkOutput("ce_frz_busy", busy, 1);
            checkOutput("ce_frz_ready", bus.req_ready, 0);
        end
        ce = 1'b1;
        collectBurst(5, 0, fw);
        checkModel("ce_resume", 20, 6, 1);

        // Reset while the second beat of an 8-beat burst is on the bus.
        applyStimulus(10'd100, 8'd8);
        waitValid("rst_wait_valid");
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midrst_valid", bus.addr_valid, 0);
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_addr", bus.addr, 0);
        checkOutput("midrst_last", bus.addr_last, 0);
        reset = 1'b0;
        for (int c = 0; c < 3; c++) begin
            checkOutput("midrst_quiet", bus.addr_valid, 0);
            @(negedge clk);
        end
        applyStimulus(10'd3, 8'd2);
        collectBurst(2, 0, fw);
        checkOutput("postrst_latency", fw, 2);
        checkModel("postrst", 3, 2, 0);

        // Randomized bursts, with some start indices near the range boundary.
        for (int n = 0; n < 40; n++) begin
            ridx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(670, 700)) : int'($urandom_range(0, 1023));
            rlen = int'($urandom_range(0, 12));
            applyStimulus(10'(ridx), 8'(rlen));
            if (rlen == 0) begin
                checkOutput("rnd_len0_valid", bus.addr_valid, 0);
                checkOutput("rnd_len0_ready", bus.req_ready, 1);
            end else begin
                collectBurst(rlen, 1, fw);
                checkOutput($sformatf("rnd%0d_latency", n), fw, 2);
                checkModel($sformatf("rnd%0d", n), ridx, rlen, 0);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
